// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - memory op encodings, access sizes and FSM states for the MEM-stage LSU
package mem_lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } lsu_state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_B;
      OP_LH, OP_LHU, OP_SH: return SIZE_H;
      default:              return SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_load_ext.sv
// rtl/mem_lsu_load_ext.sv - little-endian lane select and sign/zero extension of load data
module mem_load_ext
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Stores fall into the default arm so the W stage never sees stale bus data.
    case (op)
      OP_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  data = {24'd0, byte_lane};
      OP_LH:   data = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  data = {16'd0, half_lane};
      OP_LW:   data = rdata;
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit: alignment check, req/addr_ok/data_ok bus FSM, pipeline stall
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W-1:0] mem_wdata,
  input  logic              flush,
  input  logic              stall_in,
  output logic              stall_out,
  output logic [ADDR_W-1:0] load_data,
  output logic              load_valid,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] bad_vaddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [ADDR_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [ADDR_W-1:0] data_rdata
);

  lsu_state_t        state, state_nx;
  logic              discard;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic [ADDR_W-1:0] load_q;
  logic [ADDR_W-1:0] ext_data;
  logic [1:0]        req_size;
  logic              misalign;
  logic              is_idle;
  logic              start;
  logic              kill;

  assign req_size = op_size(mem_op);
  assign misalign = ((req_size == SIZE_H) && mem_addr[0]) ||
                    ((req_size == SIZE_W) && (mem_addr[1:0] != 2'b00));
  assign is_idle  = (state == S_IDLE);

  assign adel      = mem_valid & is_idle & misalign & ~is_store(mem_op);
  assign ades      = mem_valid & is_idle & misalign &  is_store(mem_op);
  assign bad_vaddr = (adel | ades) ? mem_addr : '0;
  assign start     = mem_valid & ~flush & ~adel & ~ades & is_idle;
  assign kill      = discard | flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    data_req   = 1'b0;
    stall_out  = start;
    load_valid = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_ADDR;
      S_ADDR: begin
        // A flushed request is still held until accepted; the bus forbids retraction.
        data_req  = 1'b1;
        stall_out = 1'b1;
        if (data_addr_ok) state_nx = S_DATA;
      end
      S_DATA: begin
        stall_out = 1'b1;
        if (data_data_ok) state_nx = kill ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        load_valid = ~is_store(op_q);
        if (!stall_in) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      discard <= 1'b0;
      op_q    <= OP_LB;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_B;
      wr_q    <= 1'b0;
      load_q  <= '0;
    end else begin
      if (start) begin
        op_q   <= mem_op;
        addr_q <= mem_addr;
        size_q <= req_size;
        wr_q   <= is_store(mem_op);
        case (req_size)
          SIZE_B:  wdata_q <= {4{mem_wdata[7:0]}};
          SIZE_H:  wdata_q <= {2{mem_wdata[15:0]}};
          default: wdata_q <= mem_wdata;
        endcase
      end
      if (state_nx == S_IDLE)
        discard <= 1'b0;
      else if (flush && ((state == S_ADDR) || (state == S_DATA)))
        discard <= 1'b1;
      if ((state == S_DATA) && data_data_ok && !kill)
        load_q <= ext_data;
    end
  end

  mem_load_ext u_load_ext (
    .op      (op_q),
    .addr_lo (addr_q[1:0]),
    .rdata   (data_rdata),
    .data    (ext_data)
  );

  assign load_data  = load_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

endmodule
